// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: bundles the requester side and the APB side of the
// shared APB3 master arbiter.
//
// Requester side:
//   req_valid_i / req_write_i  per-requester request valid and direction
//   req_addr_i / req_wdata_i   packed address / write data, slice i = requester i
//   req_ready_o / rsp_valid_o  one-hot completion pulse (identical)
//   rsp_rdata_o / rsp_err_o    shared response data and error, qualified by rsp_valid_o
//   busy_o                     arbiter is not idle
// APB side:
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA driven by the arbiter
//   PRDATA, PREADY, PSLVERR     driven by the slave
//
// Modports: master = the arbiter itself, slave = the surrounding environment.
interface apb_master_arbiter_if #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]                req_valid_i;
    logic [NUM_REQ-1:0]                req_write_i;
    logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]                req_ready_o;
    logic [APB_DATA_WIDTH-1:0]         rsp_rdata_o;
    logic                              rsp_err_o;
    logic [NUM_REQ-1:0]                rsp_valid_o;
    logic                              busy_o;

    logic                              PSEL;
    logic                              PENABLE;
    logic                              PWRITE;
    logic [APB_ADDR_WIDTH-1:0]         PADDR;
    logic [APB_DATA_WIDTH-1:0]         PWDATA;
    logic [APB_DATA_WIDTH-1:0]         PRDATA;
    logic                              PREADY;
    logic                              PSLVERR;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready_o, rsp_rdata_o, rsp_err_o, rsp_valid_o, busy_o,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready_o, rsp_rdata_o, rsp_err_o, rsp_valid_o, busy_o,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB3 master port between NUM_REQ single-beat
// valid/ready requesters with round-robin arbitration, proper SETUP/ACCESS
// sequencing and an ACCESS-phase timeout against hung slaves.
//
// Ports:
//   ACLK    clock, rising edge
//   ARESET  synchronous active-high reset
//   bus     apb_master_arbiter_if.master (requester handshake + APB signals)
//
// All outputs are decodes of registered state; PREADY/PRDATA/PSLVERR only
// reach requester outputs through the captured response registers.
module apb_master_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                  ACLK,
    input logic                  ARESET,
    apb_master_arbiter_if.master bus
);
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TimeoutLast = TimeoutEn ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
    localparam logic [IdxW-1:0] LastReset = IdxW'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           grant_q, grant_d;
    logic [IdxW-1:0]           last_grant_q, last_grant_d;
    logic                      write_q, write_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic [15:0]               cnt_q, cnt_d;

    // Round-robin pick: first valid requester after last_grant, wrapping.
    logic            gnt_found;
    logic [IdxW-1:0] gnt_idx;

    always_comb begin
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand     = (32'(last_grant_q) + k) % NUM_REQ;
            cand_idx = IdxW'(cand);
            if (!gnt_found && bus.req_valid_i[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    grant_d      = gnt_idx;
                    last_grant_d = gnt_idx;
                    write_d      = bus.req_write_i[gnt_idx];
                    addr_d       = bus.req_addr_i[gnt_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                    wdata_d      = bus.req_wdata_i[gnt_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                // Counter is cleared on the way into ACCESS.
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                if (bus.PREADY) begin
                    // Completion wins over a timeout expiring in the same cycle.
                    rdata_d = write_q ? '0 : bus.PRDATA;
                    err_d   = bus.PSLVERR;
                    state_d = StResp;
                end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= LastReset;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    logic                  on_bus;
    logic                  in_resp;
    logic [NUM_REQ-1:0]    grant_oh;

    assign on_bus   = (state_q == StSetup) || (state_q == StAccess);
    assign in_resp  = (state_q == StResp);
    assign grant_oh = NUM_REQ'(1) << grant_q;

    assign bus.PSEL        = on_bus;
    assign bus.PENABLE     = (state_q == StAccess);
    assign bus.PWRITE      = on_bus ? write_q : 1'b0;
    assign bus.PADDR       = on_bus ? addr_q : '0;
    assign bus.PWDATA      = on_bus ? wdata_q : '0;

    assign bus.req_ready_o = in_resp ? grant_oh : '0;
    assign bus.rsp_valid_o = in_resp ? grant_oh : '0;
    assign bus.rsp_rdata_o = in_resp ? rdata_q : '0;
    assign bus.rsp_err_o   = in_resp ? err_q : 1'b0;
    assign bus.busy_o      = (state_q != StIdle);
endmodule
